// File: rtl/serial_compare_32.sv
// Digit-serial magnitude comparator: one 2-bit digit pair per cycle, MSB first, fixed WIDTH/2 latency.
// Optional build macro CMP_SIGNED_EN adds a signed_mode input for two's-complement compares.
module serial_compare_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef CMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);
    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dec_q, dec_d, dlt_q, dlt_d;
    logic             lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;
    logic             accept, last;
    logic [1:0]       da, db;
    logic             dig_lt, dig_gt;
    logic [WIDTH-1:0] load_mask;
    int               dig_idx;

    // Flipping both MSBs maps two's-complement order onto unsigned order.
`ifdef CMP_SIGNED_EN
    assign load_mask = {signed_mode, {(WIDTH-1){1'b0}}};
`else
    assign load_mask = '0;
`endif

    assign accept = start && (state_q == IDLE || state_q == DONE);
    assign last   = (state_q == RUN) && (cnt_q == LAST);

    always_comb begin
        dig_idx = DIGITS - 1 - int'(cnt_q);
        da      = a_q[2*dig_idx +: 2];
        db      = b_q[2*dig_idx +: 2];
        dig_lt  = (!da[1] && db[1]) || (!(da[1] ^ db[1]) && !da[0] && db[0]);
        dig_gt  = (da[1] && !db[1]) || (!(da[1] ^ db[1]) && da[0] && !db[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        lt   = lt_q;
        gt   = gt_q;
        eq   = eq_q;
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        dec_d = dec_q;
        dlt_d = dlt_q;
        lt_d  = lt_q;
        gt_d  = gt_q;
        eq_d  = eq_q;
        if (accept) begin
            a_d   = a ^ load_mask;
            b_d   = b ^ load_mask;
            cnt_d = '0;
            dec_d = 1'b0;
            dlt_d = 1'b0;
        end else if (state_q == RUN) begin
            if (!last) cnt_d = cnt_q + 1'b1;
            // First unequal digit wins; later digits are ignored.
            if (!dec_q && (dig_lt || dig_gt)) begin
                dec_d = 1'b1;
                dlt_d = dig_lt;
            end
            if (last) begin
                lt_d = dec_q ? dlt_q  : dig_lt;
                gt_d = dec_q ? !dlt_q : dig_gt;
                eq_d = !dec_q && !dig_lt && !dig_gt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            dec_q <= 1'b0;
            dlt_q <= 1'b0;
            lt_q  <= 1'b0;
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            dec_q <= dec_d;
            dlt_q <= dlt_d;
            lt_q  <= lt_d;
            gt_q  <= gt_d;
            eq_q  <= eq_d;
        end
    end
endmodule

// File: tb/tb_serial_compare_32.sv
// Scoreboard bench for serial_compare_32 (WIDTH=32 instance plus an exhaustive WIDTH=2 instance).
module tb_serial_compare_32;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         sm = 1'b0;
    logic         busy, done, lt, gt, eq;

    logic       c_start = 1'b0;
    logic [1:0] c_a = '0, c_b = '0;
    logic       c_sm = 1'b0;
    logic       c_busy, c_done, c_lt, c_gt, c_eq;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    typedef struct {
        logic [2:0] flags;
        int         edge_no;
        string      tag;
    } exp_t;
    exp_t sb[$];

    serial_compare_32 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
`ifdef CMP_SIGNED_EN
        .signed_mode(sm),
`endif
        .busy(busy), .done(done), .lt(lt), .gt(gt), .eq(eq)
    );

    serial_compare_32 #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(c_start), .a(c_a), .b(c_b),
`ifdef CMP_SIGNED_EN
        .signed_mode(c_sm),
`endif
        .busy(c_busy), .done(c_done), .lt(c_lt), .gt(c_gt), .eq(c_eq)
    );

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        if (s) begin
            if ($signed(x) < $signed(y)) return 3'b100;
            if ($signed(x) > $signed(y)) return 3'b010;
            return 3'b001;
        end
        if (x < y) return 3'b100;
        if (x > y) return 3'b010;
        return 3'b001;
    endfunction

    // Output monitor: pops the scoreboard on every done, flags missing or spurious pulses.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("[TB] %s done at edge %0d lt=%0b gt=%0b eq=%0b", e.tag, edge_n, lt, gt, eq);
                    check({e.tag, "_flags"}, {lt, gt, eq}, e.flags);
                    check({e.tag, "_edge"}, edge_n, e.edge_no);
                    check({e.tag, "_busy_at_done"}, busy, 0);
                end
            end else if (sb.size() > 0 && edge_n >= sb[0].edge_no) begin
                e = sb.pop_front();
                check({e.tag, "_missing_done"}, 0, 1);
            end
        end
    end

    task automatic drain(input string tag);
        int k = 0;
        while (sb.size() > 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() > 0) begin
            check({tag, "_timeout"}, 0, 1);
            sb.delete();
        end
    endtask

    task automatic cmp_one(input logic [31:0] x, input logic [31:0] y, input logic s,
                           input logic [31:0] x_after, input string tag);
        exp_t e;
        @(negedge clk);
        a = x; b = y; sm = s; start = 1'b1;
        e.flags = model(x, y, s);
        e.edge_no = edge_n + 1 + W/2;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1 check({tag, "_busy_acc"}, busy, 1);
        @(negedge clk);
        start = 1'b0; a = x_after; b = $urandom; sm = ~s;
        drain(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   acc;
        logic [31:0] x, y;

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", {lt, gt, eq}, 3'b000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("idle_flags", {lt, gt, eq}, 3'b000);

        cmp_one(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'h0, "single_lt");

        // Back-to-back equal compares with start held high throughout.
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h1234_5678; sm = 1'b0; start = 1'b1;
        acc = edge_n + 1;
        for (int i = 0; i < 3; i++) begin
            e.flags = 3'b001; e.edge_no = acc + W/2 + i*(W/2+1); e.tag = "b2b_eq";
            sb.push_back(e);
        end
        while (edge_n < acc + 5) @(negedge clk);
        check("b2b_busy_run", busy, 1);
        while (edge_n < acc + 34) @(negedge clk);
        start = 1'b0;
        drain("b2b_eq");

        cmp_one(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0, "msb_gt");
        cmp_one(32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0, "lsb_gt");
        cmp_one(32'h4000_0000, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, "high_lt");
`ifdef CMP_SIGNED_EN
        cmp_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0, "signed_lt");
        cmp_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, "unsigned_gt");
        cmp_one(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0, "signed_min_lt");
`else
        cmp_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0, "unsigned_gt");
`endif
        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            case (i % 3)
                0:       y = x;
                1:       y = x ^ (32'h1 << $urandom_range(31));
                default: y = $urandom;
            endcase
            cmp_one(x, y, 1'b0, $urandom, "rand");
        end

        // Abort mid-RUN: no done may follow.
        @(negedge clk);
        a = 32'h0000_0005; b = 32'h0000_0003; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_flags", {lt, gt, eq}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("abort_no_done", done, 0);

        cmp_one(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0, "post_rst_gt");

        // Exhaustive WIDTH=2 instance, one digit so done arrives one edge after acceptance.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] p;
            logic [2:0] exp_f;
            p = 4'(i);
            @(negedge clk);
            c_a = p[3:2]; c_b = p[1:0]; c_start = 1'b1;
            exp_f = (p[3:2] < p[1:0]) ? 3'b100 : (p[3:2] > p[1:0]) ? 3'b010 : 3'b001;
            @(posedge clk);
            #1 check("w2_busy", c_busy, 1);
            @(negedge clk);
            c_start = 1'b0;
            @(posedge clk);
            #1;
            $display("[TB] w2 a=%0d b=%0d done=%0b lt=%0b gt=%0b eq=%0b", p[3:2], p[1:0], c_done, c_lt, c_gt, c_eq);
            check("w2_done", c_done, 1);
            check("w2_flags", {c_lt, c_gt, c_eq}, exp_f);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_compare_32.md
SERIAL_COMPARE_32 -- requirements
Module: serial_compare_32

Interface
REQ-001 Parameter: WIDTH, default 32, operand width in bits; SHALL be even and >= 2.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: start  input  1  request; sampled high on a rising edge while idle starts a compare.
REQ-005 Port: a  input  WIDTH  left operand; sampled only on the accepting edge.
REQ-006 Port: b  input  WIDTH  right operand; sampled only on the accepting edge.
REQ-007 Port: busy  output  1  high while a compare is in progress.
REQ-008 Port: done  output  1  single-cycle pulse; lt/gt/eq valid from this cycle.
REQ-009 Port: lt, gt, eq  output  1 each  result flags: a<b, a>b, a==b.

Function
REQ-010 States SHALL be IDLE, RUN and DONE.
  - IDLE -> RUN on start=1.
  - RUN -> DONE after WIDTH/2 digit cycles.
  - DONE -> IDLE after exactly one cycle.
REQ-011 Accepting edge k (start=1 in IDLE or DONE):
  - SHALL latch a and b into internal shift registers.
  - SHALL clear the decision state.
  - SHALL assert busy from edge k.
REQ-012 In RUN, each cycle SHALL compare one 2-bit digit pair, MSB digit first, using 2-bit less-than/greater-than logic.
REQ-013 The first unequal digit pair SHALL fix the result.
  - Later digits SHALL NOT change it.
  - No early termination: latency is fixed.
REQ-014 At edge k+WIDTH/2 (16 for WIDTH=32):
  - busy SHALL fall.
  - done SHALL rise for exactly one cycle.
  - lt/gt/eq SHALL update in the same edge.
REQ-015 Exactly one of lt, gt, eq SHALL be high after the first done; all three SHALL be low before it.
REQ-016 lt/gt/eq SHALL hold their value until the edge that registers the next result.
  - They SHALL NOT change at acceptance or during RUN.
REQ-017 start during RUN SHALL be ignored.
  - No queuing.
  - Operand registers SHALL NOT change.
REQ-018 start high during the DONE cycle SHALL be accepted.
  - busy SHALL rise on the edge after done, so back-to-back compares repeat every WIDTH/2+1 cycles.
REQ-019 Changes on a or b after the accepting edge SHALL NOT affect the result in flight.

Reset
REQ-020 On rst_n=0, without waiting for clk:
  - State SHALL go to IDLE.
  - busy, done, lt, gt, eq SHALL be 0.
  - Operand and decision registers SHALL be 0.
REQ-021 Reset asserted mid-RUN SHALL abort the compare; no done SHALL follow for the aborted operation.
REQ-022 After rst_n rises, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-023 Macro CMP_SIGNED_EN.
  - Defined: an extra input port signed_mode (1 bit, sampled on the accepting edge) SHALL exist; signed_mode=1 SHALL compare as two's complement by inverting the MSB of both operands at load; signed_mode=0 SHALL compare unsigned.
  - Undefined: signed_mode SHALL NOT exist and all compares SHALL be unsigned.
  - Latency SHALL be identical in both builds.

Verification
REQ-024 Reset mid-RUN: start with a=32'h0000_0005, b=32'h0000_0003; pulse rst_n low at cycle 5 -> busy, done, lt, gt, eq all 0 immediately; no done follows.
REQ-025 Single compare: a=32'hFFFF_FFFE, b=32'hFFFF_FFFF, start at edge 0 -> busy 1 from edge 0; done=1, lt=1, gt=0, eq=0 at edge 16; busy 0 at edge 16.
REQ-026 Equal operands with back-to-back requests:
  - Stimulus: a=b=32'h1234_5678, start held high continuously.
  - Response: eq=1 on each done; done pulses at edges 16, 33, 50.
  - Response: start during RUN has no effect.
REQ-027 MSB decides: a=32'h8000_0000, b=32'h7FFF_FFFF; change a to 0 at edge 3 -> gt=1 at edge 16.
REQ-028 Signed mode (CMP_SIGNED_EN defined): a=32'hFFFF_FFFF, b=32'h0000_0001.
  - signed_mode=1 -> lt=1.
  - signed_mode=0 -> gt=1.
  - Build without the macro -> gt=1.
REQ-029 Exhaustive low digit: WIDTH=2 build, all 16 (a,b) pairs -> lt/gt/eq match the arithmetic relation; done at edge 1 after each start.
